bp_update_sched: RTL and testbench
==================================

# bp_update_sched

Scheduler between the commit-side branch-resolve sources and the predictor's training ports. It accepts up to NUM_REQ resolved-branch updates per cycle into an in-order queue. Each cycle it issues up to NUM_UPD of them to the predictor update ports, deferring any entry whose table index collides with an older entry issued in the same cycle. It sits between commit and the predictor tables; `bp_logger_multi`-style monitors tap its `upd_*` outputs.

## Interface
- PC_WIDTH, 32, branch PC width
- META_WIDTH, 19, predictor metadata width (GHR + chooser bits)
- NUM_REQ, 3, resolve request ports
- NUM_UPD, 2, predictor update ports
- DEPTH, 8, queue entries; power of two, >= NUM_REQ
- IDX_BITS, 10, table index width; index = pc[IDX_BITS+1:2]
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-port request valid
- req_pc_i  in  PC_WIDTH x NUM_REQ  branch PC
- req_meta_i  in  META_WIDTH x NUM_REQ  metadata captured at predict
- req_taken_i  in  NUM_REQ  actual direction
- req_mispred_i  in  NUM_REQ  mispredict flag
- req_ready_o  out  1  all NUM_REQ ports may enqueue this cycle
- flush_i  in  1  synchronous queue clear
- upd_stall_i  in  1  predictor cannot accept updates this cycle
- upd_valid_o  out  NUM_UPD  per-port update valid
- upd_pc_o  out  PC_WIDTH x NUM_UPD
- upd_meta_o  out  META_WIDTH x NUM_UPD
- upd_taken_o  out  NUM_UPD
- upd_mispred_o  out  NUM_UPD
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap naturally. Occupancy is held in a separate counter.
- req_ready_o = (DEPTH - count) >= NUM_REQ. The value comes from registered count; there is no combinational path from req_valid_i.
- Enqueue happens only when req_ready_o=1. Valid requests are compacted in ascending port order, so lower port = older. Gaps in req_valid_i are allowed.
- When req_ready_o=0, valid requests are ignored. The producer must hold them.
- Issue candidates are the entries head .. head+NUM_UPD-1 that lie below count.
- Candidate k issues only if all candidates before it issued and its index differs from every index issued before it this cycle.
- The first blocked candidate stops issue for the rest of the cycle, so order is strictly preserved.
- Candidate 0 always issues when count>0 and upd_stall_i=0.
- upd_*_o are driven combinationally from queue storage. upd_valid_o is a contiguous run from bit 0.
- With upd_stall_i=1, upd_valid_o=0 and nothing dequeues.
- head advances by the number issued. tail advances by the number enqueued. count changes by (enqueued - issued) in the same edge.
- flush_i: on the next edge, head=tail=0 and count=0. Flush overrides any same-cycle enqueue and dequeue. During the flush cycle itself upd_valid_o is forced to 0.

## Timing
- Reset values: head=tail=count=0, upd_valid_o=0, count_o=0, req_ready_o=1. Data outputs are 0, and storage is not cleared.
- Latency: a request accepted at edge N appears on upd_valid_o in cycle N+1 at the earliest. There is no bypass.
- Full (count > DEPTH-NUM_REQ): req_ready_o=0. Dequeue still proceeds, and req_ready_o rises the cycle after count drops.
- Empty: upd_valid_o=0, count_o=0.
- Simultaneous enqueue and dequeue at full-threshold is legal. The count update is net.
- Asserting reset mid-operation drops all entries immediately.

## Configuration
- BP_UPDQ_STATS_EN defined: adds outputs stat_conflict_o (32 bits) and stat_backpressure_o (32 bits). Both reset to 0 and wrap on overflow.
  - stat_conflict_o increments on cycles where an index conflict blocked a candidate.
  - stat_backpressure_o increments on cycles where any req_valid_i=1 while req_ready_o=0.
  - flush_i does not clear either counter.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package bp_pkg holds:
  - typedef bp_upd_entry_t {pc, meta, taken, mispred}
  - function bp_idx(pc, IDX_BITS)
  - constants BP_META_W and BP_IDX_BITS
- One sub-module, bp_upd_conflict_chk: combinational; NUM_UPD candidate indices plus valids in, issue mask out. It is kept separate so the pairwise compare can be unit-tested.

## Test plan
- Reset, then req_valid_i=3'b111 with PCs 0x100,0x104,0x108 → cycle N+1: upd_valid_o=2'b11 with PCs 0x100,0x104. Cycle N+2: 2'b01 with 0x108. Then count_o=0.
- Enqueue PCs 0x100 and 0x1100 (same index at IDX_BITS=10) → first cycle issues 0x100 only, next cycle issues 0x1100. stat_conflict_o=1.
- Hold upd_stall_i=1 while enqueuing 3 per cycle → req_ready_o falls when count_o=6. Further requests are not enqueued, and with the macro stat_backpressure_o counts those cycles. Releasing the stall drains in order, 2 per cycle.
- Enqueue 8 distinct-index entries so the pointers wrap past 7 → output order matches input order exactly. count_o returns to 0.
- With count_o=5, assert flush_i together with a 3-request enqueue → next cycle count_o=0, upd_valid_o=0, req_ready_o=1.
- Assert rst_n low mid-drain → upd_valid_o=0 and count_o=0 immediately, asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch-predictor update scheduler.
// Holds the queued update record, the table-index helper and width constants.
package bp_pkg;

  localparam int BP_PC_W     = 32;
  localparam int BP_META_W   = 19;
  localparam int BP_IDX_BITS = 10;

  // One resolved-branch training record as it sits in the queue.
  typedef struct packed {
    logic [BP_PC_W-1:0]   pc;
    logic [BP_META_W-1:0] meta;
    logic                 taken;
    logic                 mispred;
  } bp_upd_entry_t;

  // Predictor table index: pc[idx_bits+1:2], zero-extended to BP_IDX_BITS.
  function automatic logic [BP_IDX_BITS-1:0] bp_idx(input logic [BP_PC_W-1:0] pc,
                                                    input int idx_bits);
    logic [BP_IDX_BITS-1:0] idx;
    for (int b = 0; b < BP_IDX_BITS; b++) begin
      idx[b] = (b < idx_bits) ? pc[b+2] : 1'b0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bp_upd_conflict_chk.sv
// bp_upd_conflict_chk: purely combinational issue selector.
// Candidate k issues only when every older candidate issued and its index
// differs from all of them; the first blocked candidate ends issue for the cycle.
module bp_upd_conflict_chk
  import bp_pkg::*;
#(
  parameter int NUM_UPD = 2,
  parameter int IDX_W   = BP_IDX_BITS
) (
  input  logic [NUM_UPD-1:0]       cand_valid_i,
  input  logic [NUM_UPD*IDX_W-1:0] cand_idx_i,
  output logic [NUM_UPD-1:0]       issue_o,
  output logic                     conflict_o
);

  // Walk candidates oldest first; once the run breaks nothing younger may issue.
  always_comb begin
    logic run;
    logic hit;
    issue_o    = '0;
    conflict_o = 1'b0;
    run        = 1'b1;
    for (int k = 0; k < NUM_UPD; k++) begin
      hit = 1'b0;
      // While the run is unbroken every older candidate has issued, so
      // comparing against all older candidates is the same as comparing
      // against the issued ones.
      for (int j = 0; j < k; j++) begin
        if (cand_idx_i[j*IDX_W +: IDX_W] == cand_idx_i[k*IDX_W +: IDX_W]) begin
          hit = 1'b1;
        end
      end
      if (run && cand_valid_i[k]) begin
        if (hit) begin
          conflict_o = 1'b1;
          run        = 1'b0;
        end else begin
          issue_o[k] = 1'b1;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: in-order queue between branch resolve and predictor training.
// Accepts up to NUM_REQ updates per cycle, issues up to NUM_UPD per cycle while
// deferring any entry whose table index collides with an older one issued alongside.
// Optional build macro BP_UPDQ_STATS_EN adds conflict/backpressure event counters.
// PC_WIDTH/META_WIDTH/IDX_BITS must match the bp_pkg constants used by the entry type.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = BP_PC_W,
  parameter int META_WIDTH = BP_META_W,
  parameter int NUM_REQ    = 3,
  parameter int NUM_UPD    = 2,
  parameter int DEPTH      = 8,
  parameter int IDX_BITS   = BP_IDX_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*PC_WIDTH-1:0]     req_pc_i,
  input  logic [NUM_REQ*META_WIDTH-1:0]   req_meta_i,
  input  logic [NUM_REQ-1:0]              req_taken_i,
  input  logic [NUM_REQ-1:0]              req_mispred_i,
  output logic                            req_ready_o,
  input  logic                            flush_i,
  input  logic                            upd_stall_i,
  output logic [NUM_UPD-1:0]              upd_valid_o,
  output logic [NUM_UPD*PC_WIDTH-1:0]     upd_pc_o,
  output logic [NUM_UPD*META_WIDTH-1:0]   upd_meta_o,
  output logic [NUM_UPD-1:0]              upd_taken_o,
  output logic [NUM_UPD-1:0]              upd_mispred_o,
  output logic [$clog2(DEPTH):0]          count_o
`ifdef BP_UPDQ_STATS_EN
  ,
  output logic [31:0]                     stat_conflict_o,
  output logic [31:0]                     stat_backpressure_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  bp_upd_entry_t    mem [DEPTH];

  bp_upd_entry_t    req_ent  [NUM_REQ];
  logic [PTR_W-1:0] wr_addr  [NUM_REQ];
  logic [CNT_W-1:0] enq_cnt;
  logic [CNT_W-1:0] enq_num;

  bp_upd_entry_t    cand_ent [NUM_UPD];
  logic [PTR_W-1:0] rd_addr  [NUM_UPD];
  logic [NUM_UPD-1:0]          cand_valid;
  logic [NUM_UPD*IDX_BITS-1:0] cand_idx;
  logic [NUM_UPD-1:0]          issue;
  logic                        blk_conflict;
  logic [CNT_W-1:0]            iss_cnt;

  // Room for a full request group is judged from registered occupancy only.
  assign req_ready_o = (DEPTH - int'(count_reg)) >= NUM_REQ;
  assign count_o     = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ent[gi] = '{pc:      req_pc_i[gi*PC_WIDTH +: PC_WIDTH],
                             meta:    req_meta_i[gi*META_WIDTH +: META_WIDTH],
                             taken:   req_taken_i[gi],
                             mispred: req_mispred_i[gi]};
    end
  endgenerate

  // Compact valid requests: each valid port takes the next free slot after tail.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr[i] = tail_reg + enq_cnt[PTR_W-1:0];
      if (req_valid_i[i]) begin
        enq_cnt = enq_cnt + CNT_W'(1);
      end
    end
    enq_num = req_ready_o ? enq_cnt : '0;
  end

  // Storage write; the array is never cleared, pointers and count define validity.
  always_ff @(posedge clk) begin
    if (req_ready_o && !flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i]) begin
          mem[wr_addr[i]] <= req_ent[i];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_UPD; gi++) begin : g_cand
      assign rd_addr[gi]    = head_reg + PTR_W'(gi);
      assign cand_ent[gi]   = mem[rd_addr[gi]];
      assign cand_valid[gi] = (count_reg > CNT_W'(gi)) && !upd_stall_i && !flush_i;
      assign cand_idx[gi*IDX_BITS +: IDX_BITS] = bp_idx(cand_ent[gi].pc, IDX_BITS);

      // Data lanes read straight from storage and are zero when not issuing.
      assign upd_pc_o[gi*PC_WIDTH +: PC_WIDTH]       = issue[gi] ? cand_ent[gi].pc   : '0;
      assign upd_meta_o[gi*META_WIDTH +: META_WIDTH] = issue[gi] ? cand_ent[gi].meta : '0;
      assign upd_taken_o[gi]                         = issue[gi] & cand_ent[gi].taken;
      assign upd_mispred_o[gi]                       = issue[gi] & cand_ent[gi].mispred;
    end
  endgenerate

  bp_upd_conflict_chk #(
    .NUM_UPD (NUM_UPD),
    .IDX_W   (IDX_BITS)
  ) u_conflict_chk (
    .cand_valid_i (cand_valid),
    .cand_idx_i   (cand_idx),
    .issue_o      (issue),
    .conflict_o   (blk_conflict)
  );

  assign upd_valid_o = issue;

  // Issue mask is a contiguous run from bit 0, so its popcount is the dequeue amount.
  always_comb begin
    iss_cnt = '0;
    for (int k = 0; k < NUM_UPD; k++) begin
      if (issue[k]) begin
        iss_cnt = iss_cnt + CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy update; flush wins over same-cycle enqueue/dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + iss_cnt[PTR_W-1:0];
      tail_reg  <= tail_reg + enq_num[PTR_W-1:0];
      count_reg <= count_reg + enq_num - iss_cnt;
    end
  end

`ifdef BP_UPDQ_STATS_EN
  // Event counters: conflict-blocked cycles and refused-request cycles; flush keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict_o     <= '0;
      stat_backpressure_o <= '0;
    end else begin
      if (blk_conflict) begin
        stat_conflict_o <= stat_conflict_o + 32'd1;
      end
      if ((|req_valid_i) && !req_ready_o) begin
        stat_backpressure_o <= stat_backpressure_o + 32'd1;
      end
    end
  end
`else
  logic unused_conflict;
  assign unused_conflict = blk_conflict;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed scenarios plus randomized traffic for bp_update_sched,
// checked every cycle against a queue-based reference model.
// Honors BP_UPDQ_STATS_EN to also check the event counters.
module tb_bp_update_sched;

  localparam int NR = 3;
  localparam int NU = 2;
  localparam int PW = 32;
  localparam int MW = 19;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid_i = '0;
  logic [NR*PW-1:0] req_pc_i = '0;
  logic [NR*MW-1:0] req_meta_i = '0;
  logic [NR-1:0]    req_taken_i = '0;
  logic [NR-1:0]    req_mispred_i = '0;
  logic             req_ready_o;
  logic             flush_i = 1'b0;
  logic             upd_stall_i = 1'b0;
  logic [NU-1:0]    upd_valid_o;
  logic [NU*PW-1:0] upd_pc_o;
  logic [NU*MW-1:0] upd_meta_o;
  logic [NU-1:0]    upd_taken_o;
  logic [NU-1:0]    upd_mispred_o;
  logic [3:0]       count_o;
`ifdef BP_UPDQ_STATS_EN
  logic [31:0]      stat_conflict_o;
  logic [31:0]      stat_backpressure_o;
`endif

  bp_update_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_pc_i      (req_pc_i),
    .req_meta_i    (req_meta_i),
    .req_taken_i   (req_taken_i),
    .req_mispred_i (req_mispred_i),
    .req_ready_o   (req_ready_o),
    .flush_i       (flush_i),
    .upd_stall_i   (upd_stall_i),
    .upd_valid_o   (upd_valid_o),
    .upd_pc_o      (upd_pc_o),
    .upd_meta_o    (upd_meta_o),
    .upd_taken_o   (upd_taken_o),
    .upd_mispred_o (upd_mispred_o),
    .count_o       (count_o)
`ifdef BP_UPDQ_STATS_EN
    ,
    .stat_conflict_o     (stat_conflict_o),
    .stat_backpressure_o (stat_backpressure_o)
`endif
  );

  typedef struct {
    logic [PW-1:0] pc;
    logic [MW-1:0] meta;
    logic          taken;
    logic          mispred;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_conf = 0;
  int   m_bp = 0;
  int   m_sz;
  int   m_iss;
  bit   m_rdy;
  ent_t m_e;

  function automatic int idx_of(input logic [PW-1:0] pc);
    return int'((pc / 4) % 1024);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of records; one check per cycle at the falling edge,
  // then the model steps to what the next rising edge must produce.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_conf = 0;
        m_bp = 0;
        check("rst_valid", 64'(upd_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
      end else begin
        m_sz  = q.size();
        m_rdy = (DP - m_sz) >= NR;
        m_iss = 0;
        if (!flush_i && !upd_stall_i && m_sz > 0) begin
          m_iss = 1;
          if (m_sz > 1 && idx_of(q[1].pc) != idx_of(q[0].pc)) m_iss = 2;
        end
        check("count", 64'(count_o), 64'(m_sz));
        check("ready", 64'(req_ready_o), 64'(m_rdy));
        check("valid", 64'(upd_valid_o), 64'((1 << m_iss) - 1));
        for (int p = 0; p < m_iss; p++) begin
          check("upd_pc", 64'(upd_pc_o[p*PW +: PW]), 64'(q[p].pc));
          check("upd_meta", 64'(upd_meta_o[p*MW +: MW]), 64'(q[p].meta));
          check("upd_taken", 64'(upd_taken_o[p]), 64'(q[p].taken));
          check("upd_mispred", 64'(upd_mispred_o[p]), 64'(q[p].mispred));
        end
`ifdef BP_UPDQ_STATS_EN
        check("stat_conflict", 64'(stat_conflict_o), 64'(m_conf));
        check("stat_backpressure", 64'(stat_backpressure_o), 64'(m_bp));
`endif
        if (!flush_i && !upd_stall_i && m_sz > 1 && m_iss == 1) m_conf++;
        if (req_valid_i != '0 && !m_rdy) m_bp++;
        if (flush_i) begin
          q.delete();
        end else begin
          for (int p = 0; p < m_iss; p++) void'(q.pop_front());
          if (m_rdy) begin
            for (int i = 0; i < NR; i++) begin
              if (req_valid_i[i]) begin
                m_e.pc      = req_pc_i[i*PW +: PW];
                m_e.meta    = req_meta_i[i*MW +: MW];
                m_e.taken   = req_taken_i[i];
                m_e.mispred = req_mispred_i[i];
                q.push_back(m_e);
              end
            end
          end
        end
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge and held for the cycle.
  task automatic cyc(input logic [2:0] v, input logic [31:0] p0, input logic [31:0] p1,
                     input logic [31:0] p2, input logic st, input logic fl);
    @(posedge clk);
    #1;
    req_valid_i = v;
    req_pc_i    = {p2, p1, p0};
    for (int i = 0; i < NR; i++) req_meta_i[i*MW +: MW] = MW'($urandom);
    req_taken_i   = NR'($urandom);
    req_mispred_i = NR'($urandom);
    upd_stall_i   = st;
    flush_i       = fl;
    $display("txn t=%0t v=%b pc=%h/%h/%h stall=%b flush=%b count=%0d", $time, v, p0, p1, p2,
             st, fl, count_o);
  endtask

  task automatic idle(input logic st);
    cyc(3'b000, 32'h0, 32'h0, 32'h0, st, 1'b0);
  endtask

  initial begin : main
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three requests in one cycle: two issue, then one.
    cyc(3'b111, 32'h100, 32'h104, 32'h108, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("lit_a_valid0", 64'(upd_valid_o), 64'h3);
    check("lit_a_pc0", 64'(upd_pc_o[0 +: PW]), 64'h100);
    check("lit_a_pc1", 64'(upd_pc_o[PW +: PW]), 64'h104);
    idle(1'b0);
    @(negedge clk);
    check("lit_a_valid1", 64'(upd_valid_o), 64'h1);
    check("lit_a_pc2", 64'(upd_pc_o[0 +: PW]), 64'h108);
    idle(1'b0);
    @(negedge clk);
    check("lit_a_count", 64'(count_o), 64'h0);

    // Same table index: younger entry waits one cycle.
    cyc(3'b011, 32'h100, 32'h1100, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("lit_b_valid0", 64'(upd_valid_o), 64'h1);
    check("lit_b_pc0", 64'(upd_pc_o[0 +: PW]), 64'h100);
    idle(1'b0);
    @(negedge clk);
    check("lit_b_valid1", 64'(upd_valid_o), 64'h1);
    check("lit_b_pc1", 64'(upd_pc_o[0 +: PW]), 64'h1100);
`ifdef BP_UPDQ_STATS_EN
    check("lit_b_stat_conflict", 64'(stat_conflict_o), 64'd1);
`endif

    // Stalled fill until backpressure, then in-order drain.
    cyc(3'b111, 32'h200, 32'h204, 32'h208, 1'b1, 1'b0);
    cyc(3'b111, 32'h20c, 32'h210, 32'h214, 1'b1, 1'b0);
    cyc(3'b111, 32'h218, 32'h21c, 32'h220, 1'b1, 1'b0);
    @(negedge clk);
    check("lit_c_count6", 64'(count_o), 64'd6);
    check("lit_c_ready0", 64'(req_ready_o), 64'd0);
    cyc(3'b111, 32'h218, 32'h21c, 32'h220, 1'b1, 1'b0);
    @(negedge clk);
    check("lit_c_count_hold", 64'(count_o), 64'd6);
    idle(1'b0);
    @(negedge clk);
    check("lit_c_valid", 64'(upd_valid_o), 64'h3);
    check("lit_c_pc0", 64'(upd_pc_o[0 +: PW]), 64'h200);
    check("lit_c_pc1", 64'(upd_pc_o[PW +: PW]), 64'h204);
`ifdef BP_UPDQ_STATS_EN
    check("lit_c_stat_bp", 64'(stat_backpressure_o), 64'd2);
`endif
    repeat (3) idle(1'b0);
    @(negedge clk);
    check("lit_c_empty", 64'(count_o), 64'd0);

    // Flush at occupancy 5 together with a full request group.
    cyc(3'b111, 32'h300, 32'h304, 32'h308, 1'b1, 1'b0);
    cyc(3'b011, 32'h30c, 32'h310, 32'h0, 1'b1, 1'b0);
    cyc(3'b111, 32'h400, 32'h404, 32'h408, 1'b0, 1'b1);
    @(negedge clk);
    check("lit_e_count5", 64'(count_o), 64'd5);
    check("lit_e_valid_forced0", 64'(upd_valid_o), 64'd0);
    idle(1'b0);
    @(negedge clk);
    check("lit_e_count0", 64'(count_o), 64'd0);
    check("lit_e_valid0", 64'(upd_valid_o), 64'd0);
    check("lit_e_ready1", 64'(req_ready_o), 64'd1);

    // Randomized traffic with frequent index collisions, stalls and rare flushes.
    for (int n = 0; n < 600; n++) begin
      cyc(3'($urandom),
          32'($urandom_range(0, 3) * 4096 + $urandom_range(0, 7) * 4),
          32'($urandom_range(0, 3) * 4096 + $urandom_range(0, 7) * 4),
          32'($urandom_range(0, 3) * 4096 + $urandom_range(0, 7) * 4),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset in the middle of a drain.
    cyc(3'b111, 32'h500, 32'h504, 32'h508, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("lit_f_valid", 64'(upd_valid_o), 64'd0);
    check("lit_f_count", 64'(count_o), 64'd0);
    check("lit_f_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // A little more random traffic after reset recovery.
    for (int n = 0; n < 100; n++) begin
      cyc(3'($urandom),
          32'($urandom_range(0, 1023) * 4),
          32'($urandom_range(0, 1023) * 4),
          32'($urandom_range(0, 1023) * 4),
          ($urandom_range(0, 2) == 0), 1'b0);
    end
    repeat (6) idle(1'b0);
    @(negedge clk);
    check("final_empty", 64'(count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
